// File: rtl/vcgc_pkg.sv
// Shared types for the streaming graph-coloring checker: FSM states,
// the color value type and the registered edge beat.
package vcgc_pkg;

    localparam int VCGC_NUM_V   = 30;
    localparam int VCGC_COLOR_W = 2;
    localparam int VCGC_IDX_W   = $clog2(VCGC_NUM_V);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef logic [VCGC_COLOR_W-1:0] color_t;

    typedef struct packed {
        logic [VCGC_IDX_W-1:0] u;
        logic [VCGC_IDX_W-1:0] v;
        logic                  last;
    } beat_t;

endpackage

// File: rtl/vcgc_color_table.sv
// Per-vertex color register file: one write port, two combinational read
// ports. Out-of-range writes are dropped and out-of-range reads return 0.
module vcgc_color_table #(
    parameter int NUM_V   = 30,
    parameter int COLOR_W = 2,
    parameter int IDX_W   = $clog2(NUM_V)
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COLOR_W-1:0] wr_data,
    input  logic [IDX_W-1:0]   rd_idx_a,
    output logic [COLOR_W-1:0] rd_data_a,
    input  logic [IDX_W-1:0]   rd_idx_b,
    output logic [COLOR_W-1:0] rd_data_b
);

    logic [COLOR_W-1:0] mem [NUM_V];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_V; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (int'(wr_idx) < NUM_V)) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data_a = (int'(rd_idx_a) < NUM_V) ? mem[rd_idx_a] : '0;
    assign rd_data_b = (int'(rd_idx_b) < NUM_V) ? mem[rd_idx_b] : '0;

endmodule

// File: rtl/vcgc_stream_checker.sv
// Streaming coloring checker: compares endpoint colors of each handshaken edge.
// Optional macro VCGC_COLOR_RANGE_EN also flags colors >= NUM_COLORS as conflicts.
module vcgc_stream_checker
    import vcgc_pkg::*;
#(
    parameter int NUM_V      = VCGC_NUM_V,
    parameter int COLOR_W    = VCGC_COLOR_W,
    parameter int IDX_W      = $clog2(NUM_V),
    parameter int CNT_W      = 16,
    parameter int NUM_COLORS = 4
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               col_we,
    input  logic [IDX_W-1:0]   col_idx,
    input  logic [COLOR_W-1:0] col_data,
    input  logic               start,
    input  logic               edge_valid,
    output logic               edge_ready,
    input  logic [IDX_W-1:0]   edge_u,
    input  logic [IDX_W-1:0]   edge_v,
    input  logic               edge_last,
    output logic               busy,
    output logic               done,
    output logic               valid_coloring,
    output logic [CNT_W-1:0]   conflict_count,
    output logic [IDX_W-1:0]   first_u,
    output logic [IDX_W-1:0]   first_v,
    output logic               idx_err
);

    state_t state_q, state_d;
    beat_t  s1_beat;
    logic   s1_valid;
    color_t cu, cv;

    logic accept, idle_like, table_we, run_start;
    logic u_ok, v_ok, idx_bad, range_bad, conflict;

    assign accept    = edge_valid && edge_ready;
    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign table_we  = col_we && idle_like;
    assign run_start = start && idle_like;

    vcgc_color_table #(
        .NUM_V   (NUM_V),
        .COLOR_W (COLOR_W),
        .IDX_W   (IDX_W)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .we        (table_we),
        .wr_idx    (col_idx),
        .wr_data   (col_data),
        .rd_idx_a  (s1_beat.u),
        .rd_data_a (cu),
        .rd_idx_b  (s1_beat.v),
        .rd_data_b (cv)
    );

    assign u_ok    = int'(s1_beat.u) < NUM_V;
    assign v_ok    = int'(s1_beat.v) < NUM_V;
    assign idx_bad = !(u_ok && v_ok);

`ifdef VCGC_COLOR_RANGE_EN
    assign range_bad = (int'(cu) >= NUM_COLORS) || (int'(cv) >= NUM_COLORS);
`else
    assign range_bad = 1'b0;
`endif

    // Out-of-range endpoints only raise idx_err; they never count as conflicts.
    assign conflict = !idx_bad && ((s1_beat.u == s1_beat.v) || (cu == cv) || range_bad);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
            RUN:        if (accept && edge_last) state_d = DRAIN;
            DRAIN:      if (s1_valid && s1_beat.last) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        edge_ready     = (state_q == RUN);
        busy           = (state_q == RUN) || (state_q == DRAIN);
        done           = (state_q == DONE);
        valid_coloring = (state_q == DONE) && (conflict_count == '0) && !idx_err;
    end

    // Stage 1 registers the beat; the verdict registers update one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid       <= 1'b0;
            s1_beat        <= '0;
            conflict_count <= '0;
            first_u        <= '0;
            first_v        <= '0;
            idx_err        <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_beat <= '{u: edge_u, v: edge_v, last: edge_last};
            end
            if (run_start) begin
                conflict_count <= '0;
                first_u        <= '0;
                first_v        <= '0;
                idx_err        <= 1'b0;
            end else if (s1_valid) begin
                if (idx_bad) begin
                    idx_err <= 1'b1;
                end
                if (conflict) begin
                    if (conflict_count != '1) begin
                        conflict_count <= conflict_count + CNT_W'(1);
                    end
                    if (conflict_count == '0) begin
                        first_u <= s1_beat.u;
                        first_v <= s1_beat.v;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vcgc_stream_checker.sv
// Scoreboard bench for vcgc_stream_checker; expected verdicts come from a
// behavioural color-table model and are popped when done rises.
module tb_vcgc_stream_checker;
    import vcgc_pkg::*;

    localparam int NUM_V      = 30;
    localparam int COLOR_W    = 2;
    localparam int IDX_W      = 5;
    localparam int CNT_W      = 2;
    localparam int NUM_COLORS = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               col_we;
    logic [IDX_W-1:0]   col_idx;
    logic [COLOR_W-1:0] col_data;
    logic               start;
    logic               edge_valid;
    logic               edge_ready;
    logic [IDX_W-1:0]   edge_u;
    logic [IDX_W-1:0]   edge_v;
    logic               edge_last;
    logic               busy;
    logic               done;
    logic               valid_coloring;
    logic [CNT_W-1:0]   conflict_count;
    logic [IDX_W-1:0]   first_u;
    logic [IDX_W-1:0]   first_v;
    logic               idx_err;

    vcgc_stream_checker #(
        .NUM_V      (NUM_V),
        .COLOR_W    (COLOR_W),
        .IDX_W      (IDX_W),
        .CNT_W      (CNT_W),
        .NUM_COLORS (NUM_COLORS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .col_we         (col_we),
        .col_idx        (col_idx),
        .col_data       (col_data),
        .start          (start),
        .edge_valid     (edge_valid),
        .edge_ready     (edge_ready),
        .edge_u         (edge_u),
        .edge_v         (edge_v),
        .edge_last      (edge_last),
        .busy           (busy),
        .done           (done),
        .valid_coloring (valid_coloring),
        .conflict_count (conflict_count),
        .first_u        (first_u),
        .first_v        (first_v),
        .idx_err        (idx_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int u;
        int v;
    } edge_t;

    typedef struct packed {
        logic             valid;
        logic [CNT_W-1:0] count;
        logic [IDX_W-1:0] fu;
        logic [IDX_W-1:0] fv;
        logic             ierr;
    } verdict_t;

    verdict_t exp_q[$];
    edge_t    edges[$];
    int       model_col[NUM_V];
    int       total = 0;
    int       bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_color(input int idx, input int col);
        col_we   = 1'b1;
        col_idx  = IDX_W'(idx);
        col_data = COLOR_W'(col);
        tick();
        col_we = 1'b0;
        if (idx < NUM_V) model_col[idx] = col;
    endtask

    task automatic add_edge(input int u, input int v);
        edge_t e;
        e.u = u;
        e.v = v;
        edges.push_back(e);
    endtask

    task automatic push_expected();
        verdict_t ex;
        int  cnt;
        bit  bad_c;
        cnt = 0;
        ex  = '0;
        foreach (edges[i]) begin
            if (edges[i].u >= NUM_V || edges[i].v >= NUM_V) begin
                ex.ierr = 1'b1;
            end else begin
                bad_c = (edges[i].u == edges[i].v) ||
                        (model_col[edges[i].u] == model_col[edges[i].v]);
`ifdef VCGC_COLOR_RANGE_EN
                bad_c = bad_c || (model_col[edges[i].u] >= NUM_COLORS) ||
                        (model_col[edges[i].v] >= NUM_COLORS);
`endif
                if (bad_c) begin
                    if (cnt == 0) begin
                        ex.fu = IDX_W'(edges[i].u);
                        ex.fv = IDX_W'(edges[i].v);
                    end
                    if (cnt < (1 << CNT_W) - 1) cnt++;
                end
            end
        end
        ex.count = CNT_W'(cnt);
        ex.valid = (cnt == 0) && !ex.ierr;
        exp_q.push_back(ex);
    endtask

    // Starts a run (optionally with a same-cycle table write), streams the
    // edge queue and returns how many cycles after the last accept done rose.
    task automatic run_edges(input bit gaps, input bit wr_en, input int wr_idx,
                             input int wr_col, input bit poke, output int lat);
        int i;
        int cycles;
        bit fired;
        if (wr_en) begin
            col_we   = 1'b1;
            col_idx  = IDX_W'(wr_idx);
            col_data = COLOR_W'(wr_col);
            model_col[wr_idx] = wr_col;
        end
        push_expected();
        start = 1'b1;
        tick();
        start  = poke;
        col_we = poke;
        if (poke) begin
            col_idx  = IDX_W'(edges[edges.size()-1].v);
            col_data = COLOR_W'(model_col[edges[edges.size()-1].u]);
        end
        i = 0;
        cycles = 0;
        while (i < edges.size() && cycles < 200) begin
            edge_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            edge_u     = IDX_W'(edges[i].u);
            edge_v     = IDX_W'(edges[i].v);
            edge_last  = (i == edges.size() - 1);
            @(negedge clk);
            fired = edge_valid && edge_ready;
            tick();
            if (fired) i++;
            cycles++;
        end
        edge_valid = 1'b0;
        edge_last  = 1'b0;
        start      = 1'b0;
        col_we     = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (i < edges.size()) lat = -1;
    endtask

    task automatic check_verdict(input string name, input int lat);
        verdict_t obs;
        verdict_t ex;
        obs = {valid_coloring, conflict_count, first_u, first_v, idx_err};
        ex  = exp_q.pop_front();
        total++;
        if (lat != 2) begin
            bad++;
            $display("[TB] FAIL %s_latency: got %0d cycles want 2", name, lat);
        end
        total++;
        if (obs !== ex) begin
            bad++;
            $display("[TB] FAIL %s_verdict: got valid=%b cnt=%0d first=(%0d,%0d) ierr=%b want valid=%b cnt=%0d first=(%0d,%0d) ierr=%b",
                     name, obs.valid, obs.count, obs.fu, obs.fv, obs.ierr,
                     ex.valid, ex.count, ex.fu, ex.fv, ex.ierr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2*IDX_W+CNT_W+4:0] obs;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        foreach (model_col[i]) model_col[i] = 0;
        @(negedge clk);
        obs = {edge_ready, busy, done, valid_coloring, conflict_count, first_u, first_v, idx_err};
        total++;
        if (obs !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %h want 0", obs);
        end
        tick();
    endtask

    task automatic test_valid_triangle();
        int lat;
        write_color(0, 0);
        write_color(1, 1);
        write_color(2, 2);
        edges.delete();
        add_edge(0, 1);
        add_edge(1, 2);
        add_edge(0, 2);
        run_edges(1'b0, 1'b0, 0, 0, 1'b0, lat);
        check_verdict("valid_triangle", lat);
    endtask

    task automatic test_conflict_triangle();
        int lat;
        write_color(2, 1);
        run_edges(1'b0, 1'b0, 0, 0, 1'b0, lat);
        check_verdict("conflict_triangle", lat);
    endtask

    task automatic test_self_loop();
        int lat;
        write_color(5, 3);
        write_color(6, 0);
        write_color(7, 1);
        edges.delete();
        add_edge(5, 5);
        add_edge(6, 7);
        run_edges(1'b0, 1'b0, 0, 0, 1'b0, lat);
        check_verdict("self_loop", lat);
    endtask

    task automatic test_idx_err();
        int lat;
        edges.delete();
        add_edge(31, 2);
        run_edges(1'b0, 1'b0, 0, 0, 1'b0, lat);
        check_verdict("idx_err", lat);
        edges.delete();
        add_edge(0, 1);
        run_edges(1'b0, 1'b0, 0, 0, 1'b0, lat);
        check_verdict("idx_err_cleared", lat);
    endtask

    task automatic test_saturation();
        int lat;
        for (int i = 10; i <= 15; i++) write_color(i, 2);
        edges.delete();
        for (int i = 10; i < 15; i++) add_edge(i, i + 1);
        run_edges(1'b1, 1'b0, 0, 0, 1'b0, lat);
        check_verdict("saturation", lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        write_color(20, 1);
        write_color(21, 1);
        edges.delete();
        add_edge(20, 21);
        run_edges(1'b0, 1'b1, 21, 2, 1'b0, lat);
        check_verdict("start_with_write", lat);
        write_color(22, 0);
        write_color(23, 1);
        edges.delete();
        add_edge(9, 9);
        add_edge(22, 23);
        run_edges(1'b1, 1'b0, 0, 0, 1'b1, lat);
        check_verdict("write_ignored_in_run", lat);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [2*IDX_W+CNT_W+4:0] obs;
        write_color(1, 1);
        start = 1'b1;
        tick();
        start      = 1'b0;
        edge_valid = 1'b1;
        edge_u     = IDX_W'(1);
        edge_v     = IDX_W'(1);
        edge_last  = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        edge_valid = 1'b0;
        foreach (model_col[i]) model_col[i] = 0;
        @(negedge clk);
        obs = {edge_ready, busy, done, valid_coloring, conflict_count, first_u, first_v, idx_err};
        total++;
        if (obs !== '0) begin
            bad++;
            $display("[TB] FAIL reset_mid_run: got %h want 0", obs);
        end
        tick();
        edges.delete();
        add_edge(0, 1);
        run_edges(1'b0, 1'b0, 0, 0, 1'b0, lat);
        check_verdict("table_cleared", lat);
    endtask

`ifdef VCGC_COLOR_RANGE_EN
    task automatic test_color_range();
        int lat;
        write_color(0, 3);
        write_color(1, 0);
        edges.delete();
        add_edge(0, 1);
        run_edges(1'b0, 1'b0, 0, 0, 1'b0, lat);
        check_verdict("color_range", lat);
    endtask
`endif

    initial begin
        rst        = 1'b1;
        col_we     = 1'b0;
        col_idx    = '0;
        col_data   = '0;
        start      = 1'b0;
        edge_valid = 1'b0;
        edge_u     = '0;
        edge_v     = '0;
        edge_last  = 1'b0;
        test_reset();
        test_valid_triangle();
        test_conflict_triangle();
        test_self_loop();
        test_idx_err();
        test_saturation();
        test_back_to_back();
        test_reset_mid_run();
`ifdef VCGC_COLOR_RANGE_EN
        test_color_range();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
